serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial adder/subtractor for the adders lab set. It computes A+B+Cin or A−B on WIDTH-bit operands, one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It has a start/busy/done handshake and is the sequential, area-minimal counterpart to the parallel adders. Its result ports match the parallel adders (Sum, Cout), so the existing 8-bit directed vectors apply unchanged.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- Sub  in  1  0 = add (A+B+Cin), 1 = subtract (A+~B+1; Cin ignored)
- A  in  WIDTH  operand A; sampled with start
- B  in  WIDTH  operand B; sampled with start
- Cin  in  1  carry-in for add; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the result becomes valid
- Sum  out  WIDTH  registered result
- Cout  out  1  carry out; in subtract mode 1 = no borrow (A ≥ B unsigned)
- Ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1 at a clock edge.
  - Latch A into shift register ra.
  - Latch B (Sub=0) or ~B (Sub=1) into shift register rb.
  - Load carry flop c with Cin (Sub=0) or 1 (Sub=1).
  - Clear bit counter cnt.
  - Clear accumulator rs.
- RUN, each edge:
  - rs ← {s, rs[WIDTH-1:1]}, where s = ra[0]^rb[0]^c.
  - c ← majority(ra[0], rb[0], c).
  - ra and rb shift right by one.
  - cnt increments.
  - On the edge where cnt = WIDTH-1, also capture cmsb = carry into the MSB (the c value used for bit WIDTH-1).
- RUN → DONE on the edge that processes bit WIDTH-1. On that edge:
  - Sum ← final accumulator.
  - Cout ← final carry.
  - Ovf ← cmsb ^ final carry.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE. There is no queuing; a held start is accepted on the first edge in IDLE.
- Sum, Cout and Ovf change only on the RUN→DONE edge. They hold their values until the next completion or reset.
- The A, B, Cin and Sub inputs may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, and all internal registers cleared.
  - Reset mid-RUN aborts the operation. The outputs show zeros, not partial results.
  - After reset deasserts, the block needs a fresh start.
- Start accepted at edge k:
  - busy=1 from edge k to edge k+WIDTH.
  - Result is valid and done=1 from edge k+WIDTH to edge k+WIDTH+1.
  - busy and done are never high together.
- Latency from start to done is WIDTH cycles (8 for the default width).
- Back-to-back issue interval is WIDTH+2 cycles:
  - start held high → next acceptance at edge k+WIDTH+2.
- busy and done are registered outputs with no combinational path from any input.

## Structure
- Shared package (adders_pkg):
  - State encodings for IDLE, RUN, DONE (2-bit).
  - Default WIDTH.
- Counter width is $clog2(WIDTH).
- One sub-module: full_adder (a, b, cin → s, cout), instantiated once for the serial bit cell.
- Everything else lives in serial_addsub: FSM, shift registers, carry flop, output registers.

## Test plan
- Add, WIDTH=8:
  - A=05, B=03, Cin=0, Sub=0, start at edge k → done at edge k+8, Sum=08, Cout=0, Ovf=0.
  - busy=1 for exactly 8 cycles.
- Carry and overflow:
  - FF+01, Cin=0 → Sum=00, Cout=1, Ovf=0.
  - 7F+01, Cin=1 → Sum=81, Cout=0, Ovf=1.
  - AA+55, Cin=0 → Sum=FF, Cout=0, Ovf=0.
- Subtract:
  - 10−20 → Sum=F0, Cout=0, Ovf=0.
  - 80−01 → Sum=7F, Cout=1, Ovf=1.
  - 20−20 with Cin=0 → Sum=00, Cout=1 (confirms Cin is ignored).
- Handshake:
  - Pulse start again at edge k+3 while busy → ignored; the single done at k+8 carries the first result.
  - Hold start high continuously → second acceptance at edge k+10.
  - Change A/B at edge k+1 → no effect on the first result.
- Reset mid-op: assert rst at edge k+4 of a FF+01 operation.
  - busy, done, Sum, Cout and Ovf go to 0 immediately (asynchronously).
  - No done pulse follows.
  - A new start after release completes correctly.
- Result hold: after done, leave start low for 20 cycles → Sum, Cout and Ovf remain stable and done stays 0.

Source files
------------

// File: rtl/adders_pkg.sv
// -----------------------------------------------------------------------------
// adders_pkg
//   Definitions shared by the adders lab set.
//   - DEFAULT_WIDTH : default operand/result width of the serial adder
//   - state_t       : 2-bit state encoding for the serial adder/subtractor FSM
// -----------------------------------------------------------------------------
package adders_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adders_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder. This is the one arithmetic cell of the serial
//   adder.
//   Ports:
//     a, b, cin : addend bits and carry in
//     s         : sum bit
//     cout      : carry out, the majority of a, b and cin
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. It processes one bit per clock, LSB first,
//   through a single full_adder cell and a carry flop.
//   Sub=0 computes A+B+Cin. Sub=1 computes A+~B+1, and Cin is ignored.
//   Ports:
//     clk, rst   : rising-edge clock, asynchronous active-high reset
//     start      : request, sampled only in IDLE
//     Sub        : 0 = add, 1 = subtract
//     A, B, Cin  : operands and carry in, sampled on the accepting edge
//     busy       : high while the operation runs
//     done       : one-cycle pulse when Sum/Cout/Ovf become valid
//     Sum        : registered WIDTH-bit result
//     Cout       : carry out (in subtract mode, 1 = no borrow)
//     Ovf        : two's-complement overflow
//   Timing: start is accepted at edge k. busy is high from edge k to edge
//   k+WIDTH. done is high from edge k+WIDTH to edge k+WIDTH+1.
// -----------------------------------------------------------------------------
module serial_addsub
    import adders_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [WIDTH-1:0]   rs;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_cout;
    logic               last_bit;

    full_adder u_cell (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments, so every
    // flop samples the values from before the edge, whatever the order of the
    // statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment comes before the case statement. This gives
    // state_nxt a value on every path, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // busy and done are decoded straight from the state flops. No input
    // reaches them combinationally.
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Datapath: the shift registers, the carry flop, the bit counter and the
    // result registers.
    // NOTE: every internal register is cleared on reset, not only the outputs.
    // An aborted operation then leaves no partial operands or partial result
    // behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
            Ovf  <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            ra  <= A;
            // Subtraction is performed as A + ~B + 1.
            rb  <= Sub ? ~B : B;
            c   <= Sub ? 1'b1 : Cin;
            cnt <= '0;
            rs  <= '0;
        end else if (state == ST_RUN) begin
            rs  <= {fa_s, rs[WIDTH-1:1]};
            c   <= fa_cout;
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
                Sum  <= {fa_s, rs[WIDTH-1:1]};
                Cout <= fa_cout;
                // On the last-bit edge, c holds the carry into the MSB.
                Ovf  <= c ^ fa_cout;
            end
        end
    end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub with WIDTH=8. Inputs are driven and
//   outputs are sampled on the falling clock edge. A queue holds the expected
//   results, which are compared when done pulses.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    // Independent reference model: a (W+1)-bit add. Overflow is found from
    // the operand and result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum  = s;
        e.cout = co;
        e.ovf  = ov;
        return e;
    endfunction

    // Applies start for one edge. The task returns half a cycle after the
    // accepting edge k.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub);
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then compares the result with the scoreboard
    // head. waited counts the falling edges between the call and done.
    task automatic collect(input string name, output int waited);
        exp_t e;
        bit   seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: done not seen within 40 cycles", name);
        end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected done: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            n_checks += 3;
            if (Sum !== e.sum) begin
                n_fail++;
                $display("FAIL %s Sum: got %h want %h", name, Sum, e.sum);
            end
            if (Cout !== e.cout) begin
                n_fail++;
                $display("FAIL %s Cout: got %b want %b", name, Cout, e.cout);
            end
            if (Ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL %s Ovf: got %b want %b", name, Ovf, e.ovf);
            end
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy with done: got %b want 0", name, busy);
            end
        end
    endtask

    task automatic expect_wait(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({busy, done, Sum, Cout, Ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset state: got busy=%b done=%b Sum=%h Cout=%b Ovf=%b want all 0",
                     busy, done, Sum, Cout, Ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add;
        int busy_cnt;
        sb.push_back(mk(8'h08, 1'b0, 1'b0));
        drive_start(8'h05, 8'h03, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        expect_wait("add busy cycles", busy_cnt, W);
        begin
            int w;
            collect("add 05+03", w);
        end
    endtask

    task automatic test_vectors;
        int w;
        sb.push_back(mk(8'h00, 1'b1, 1'b0));
        drive_start(8'hFF, 8'h01, 1'b0, 1'b0);
        collect("add FF+01", w);
        expect_wait("add FF+01", w, W);
        sb.push_back(mk(8'h81, 1'b0, 1'b1));
        drive_start(8'h7F, 8'h01, 1'b1, 1'b0);
        collect("add 7F+01+1", w);
        sb.push_back(mk(8'hFF, 1'b0, 1'b0));
        drive_start(8'hAA, 8'h55, 1'b0, 1'b0);
        collect("add AA+55", w);
        sb.push_back(mk(8'hF0, 1'b0, 1'b0));
        drive_start(8'h10, 8'h20, 1'b0, 1'b1);
        collect("sub 10-20", w);
        sb.push_back(mk(8'h7F, 1'b1, 1'b1));
        drive_start(8'h80, 8'h01, 1'b0, 1'b1);
        collect("sub 80-01", w);
        sb.push_back(mk(8'h00, 1'b1, 1'b0));
        drive_start(8'h20, 8'h20, 1'b0, 1'b1);
        collect("sub 20-20 cin0", w);
    endtask

    task automatic test_ignore_start;
        int w;
        sb.push_back(mk(8'h30, 1'b0, 1'b0));
        drive_start(8'h10, 8'h20, 1'b0, 1'b0);   // now at k+0.5
        // Change the operands right after acceptance. This must not matter.
        A = 8'hFF; B = 8'hFF; Cin = 1'b1; Sub = 1'b1;
        repeat (2) @(negedge clk);               // k+2.5
        start = 1'b1;                            // seen at edge k+3 while busy
        @(negedge clk);
        start = 1'b0;
        collect("ignore start", w);
        expect_wait("ignore start", w, W - 3);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) break;
        end
        expect_bit("no second done", done, 1'b0);
    endtask

    task automatic test_back_to_back;
        int w;
        sb.push_back(mk(8'hC8, 1'b0, 1'b1));
        sb.push_back(mk(8'hC8, 1'b0, 1'b1));
        @(negedge clk);
        A = 8'h64; B = 8'h64; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        @(negedge clk);                          // k+0.5, start held
        collect("held start #1", w);
        expect_wait("held start #1", w, W);
        @(negedge clk);                          // k+9.5
        expect_bit("held start idle busy", busy, 1'b0);
        @(negedge clk);                          // k+10.5
        expect_bit("held start reaccept busy", busy, 1'b1);
        start = 1'b0;
        collect("held start #2", w);
        expect_wait("held start #2", w, W);
    endtask

    task automatic test_reset_mid_op;
        int w;
        drive_start(8'hFF, 8'h01, 1'b0, 1'b0);   // k+0.5
        repeat (3) @(negedge clk);               // k+3.5
        @(posedge clk);                          // edge k+4
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, Sum, Cout, Ovf} !== '0) begin
            n_fail++;
            $display("FAIL mid-op reset: got busy=%b done=%b Sum=%h Cout=%b Ovf=%b want all 0",
                     busy, done, Sum, Cout, Ovf);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        expect_bit("no done after reset", done, 1'b0);
        sb.push_back(mk(8'h00, 1'b1, 1'b0));
        drive_start(8'hFF, 8'h01, 1'b0, 1'b0);
        collect("restart after reset", w);
        expect_wait("restart after reset", w, W);
    endtask

    task automatic test_hold;
        logic [W-1:0] s0;
        logic         c0;
        logic         o0;
        s0 = Sum; c0 = Cout; o0 = Ovf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (Sum !== s0 || Cout !== c0 || Ovf !== o0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got Sum=%h Cout=%b Ovf=%b done=%b want %h %b %b 0",
                         i, Sum, Cout, Ovf, done, s0, c0, o0);
            end
        end
    endtask

    task automatic test_random;
        int           w;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb_sub;
        for (int i = 0; i < 24; i++) begin
            a      = W'($urandom_range(0, 255));
            b      = W'($urandom_range(0, 255));
            ci     = 1'($urandom_range(0, 1));
            sb_sub = 1'($urandom_range(0, 1));
            sb.push_back(model(a, b, ci, sb_sub));
            drive_start(a, b, ci, sb_sub);
            collect("random", w);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        test_reset();
        test_add();
        test_vectors();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_addsub
